logic_gate_pipe: RTL

LOGIC_GATE_PIPE -- requirements
Module: logic_gate_pipe

---
 rtl/logic_gate_pipe.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/logic_gate_pipe.sv
// Bitwise gate pipeline with single-shot and accumulating-burst modes.
// One result register stage; valid/ready handshake on both sides.
module logic_gate_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc_en,
  input  logic             last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [CNT_W-1:0] beats,
  output logic             ovf
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [WIDTH-1:0] base_f(
    input logic [1:0]       sel,
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y
  );
    logic [WIDTH-1:0] r;
    unique case (sel)
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      2'b10:   r = x ^ y;
      default: r = x;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic             ovf_q, ovf_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic             ovfo_q, ovfo_d;

  logic             accept;
  logic             emit;
  logic             sat;
  logic [WIDTH-1:0] beat_v;
  logic [WIDTH-1:0] fold_v;
  logic [CNT_W-1:0] cnt_inc;

  assign in_ready  = !vld_q || out_ready;
  assign accept    = in_valid && in_ready;
  assign emit      = vld_q && out_ready;
  assign out_valid = vld_q;
  assign f         = f_q;
  assign beats     = beats_q;
  assign ovf       = ovfo_q;

  assign beat_v  = base_f(op[1:0], a, b);
  assign fold_v  = base_f(op_q[1:0], acc_q, base_f(op_q[1:0], a, b));
  assign sat     = (cnt_q == CNT_MAX);
  assign cnt_inc = sat ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ovf_d   = ovf_q;
    vld_d   = vld_q;
    f_d     = f_q;
    beats_d = beats_q;
    ovfo_d  = ovfo_q;
    if (emit) vld_d = 1'b0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (!acc_en || last) begin
            f_d     = op[2] ? ~beat_v : beat_v;
            beats_d = CNT_ONE;
            ovfo_d  = 1'b0;
            vld_d   = 1'b1;
          end else begin
            acc_d   = beat_v;
            op_d    = op;
            cnt_d   = CNT_ONE;
            ovf_d   = 1'b0;
            state_d = ACCUM;
          end
        end
        ACCUM: begin
          if (last) begin
            f_d     = op_q[2] ? ~fold_v : fold_v;
            beats_d = cnt_inc;
            ovfo_d  = ovf_q | sat;
            vld_d   = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            state_d = IDLE;
          end else begin
            acc_d = fold_v;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | sat;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
      f_q     <= '0;
      beats_q <= '0;
      ovfo_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
      f_q     <= f_d;
      beats_q <= beats_d;
      ovfo_q  <= ovfo_d;
    end
  end

endmodule
